// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Brief    : Serializes parallel bitstream words into a tile's configuration
//            chain head and returns the bits leaving its tail as readback words.
// Revision : 1.0
// ============================================================================
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 65,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int c_NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int c_R      = CHAIN_LEN - (c_NWORDS - 1) * WORD_W;
    localparam int c_BCW    = $clog2(CHAIN_LEN + 1);
    localparam int c_WCW    = $clog2(c_NWORDS + 1);
    localparam int c_SCW    = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_SHIFT     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_word_end;
    logic                w_last_word;
    logic [c_BCW-1:0]    w_bit_cnt_inc;
    logic [WORD_W-1:0]   w_rb_full;
    logic [c_SCW-1:0]    w_pad;

    logic [c_BCW-1:0]    r_bit_cnt;
    logic [c_WCW-1:0]    r_word_cnt;
    logic [c_SCW-1:0]    r_sub_cnt;
    logic [c_SCW-1:0]    r_word_bits;
    logic [WORD_W-1:0]   r_sreg;
    logic [WORD_W-1:0]   r_rb_shift;
    logic [WORD_W-1:0]   r_rb_data;
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;
    logic                r_head;
    logic                r_shift_en;
    logic                r_rb_valid;

    assign w_bit_cnt_inc = r_bit_cnt + c_BCW'(1);
    assign w_last_word   = (r_word_cnt == c_WCW'(c_NWORDS - 1));
    // r_sub_cnt counts bits still to go after the one currently on the head
    assign w_rb_full     = (r_rb_shift << 1) | WORD_W'(ccff_tail);
    assign w_pad         = c_SCW'(WORD_W) - r_word_bits;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_word_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_sub_cnt == '0) begin
                    w_word_end   = 1'b1;
                    w_state_next = (w_bit_cnt_inc == c_BCW'(CHAIN_LEN)) ? S_DONE : S_WAIT_WORD;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are flops loaded from the next-state decode so they align with r_state
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_sub_cnt   <= '0;
            r_word_bits <= '0;
            r_sreg      <= '0;
            r_rb_shift  <= '0;
            r_rb_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_rb_valid  <= 1'b0;
        end else begin
            r_busy     <= (w_state_next == S_WAIT_WORD) || (w_state_next == S_SHIFT);
            r_in_ready <= (w_state_next == S_WAIT_WORD);
            r_shift_en <= (w_state_next == S_SHIFT);
            r_done     <= (w_state_next == S_DONE);
            r_rb_valid <= w_word_end;

            if ((r_state == S_IDLE) && start) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end

            if (w_accept) begin
                r_head      <= in_data[WORD_W-1];
                r_sreg      <= in_data << 1;
                r_sub_cnt   <= w_last_word ? c_SCW'(c_R - 1) : c_SCW'(WORD_W - 1);
                r_word_bits <= w_last_word ? c_SCW'(c_R) : c_SCW'(WORD_W);
                r_word_cnt  <= r_word_cnt + c_WCW'(1);
                r_rb_shift  <= '0;
            end

            if (r_state == S_SHIFT) begin
                r_bit_cnt  <= w_bit_cnt_inc;
                r_rb_shift <= w_rb_full;
                if (w_word_end) begin
                    r_rb_data <= w_rb_full << w_pad;
                end else begin
                    r_head    <= r_sreg[WORD_W-1];
                    r_sreg    <= r_sreg << 1;
                    r_sub_cnt <= r_sub_cnt - c_SCW'(1);
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign in_ready      = r_in_ready;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign rb_data       = r_rb_data;
    assign rb_valid      = r_rb_valid;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_bitstream_loader
// Brief    : Directed bench for ccff_bitstream_loader with behavioural chains.
// Revision : 1.0
// ============================================================================
module tb_ccff_bitstream_loader;

    logic prog_clk = 1'b0;
    logic pReset;
    always #5 prog_clk = ~prog_clk;

    int n_checks = 0;
    int n_errors = 0;

    // a: 65-bit chain, b: 16-bit chain, c: 1-bit chain
    logic       a_start, a_busy, a_done, a_in_valid, a_in_ready, a_head, a_shift_en, a_tail, a_rb_valid;
    logic       b_start, b_busy, b_done, b_in_valid, b_in_ready, b_head, b_shift_en, b_tail, b_rb_valid;
    logic       c_start, c_busy, c_done, c_in_valid, c_in_ready, c_head, c_shift_en, c_tail, c_rb_valid;
    logic [7:0] a_in_data, a_rb_data, b_in_data, b_rb_data, c_in_data, c_rb_data;

    logic [64:0] a_chain, a_pre_val;
    logic [15:0] b_chain, b_pre_val;
    logic        c_chain, c_pre_val;
    logic        a_pre_en, b_pre_en, c_pre_en;

    ccff_bitstream_loader #(.CHAIN_LEN(65), .WORD_W(8)) u_dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(a_start), .busy(a_busy), .done(a_done),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .ccff_head(a_head),
        .ccff_shift_en(a_shift_en), .ccff_tail(a_tail), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
    );
    ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(b_start), .busy(b_busy), .done(b_done),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .ccff_head(b_head),
        .ccff_shift_en(b_shift_en), .ccff_tail(b_tail), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
    );
    ccff_bitstream_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_dut_c (
        .prog_clk(prog_clk), .pReset(pReset), .start(c_start), .busy(c_busy), .done(c_done),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready), .ccff_head(c_head),
        .ccff_shift_en(c_shift_en), .ccff_tail(c_tail), .rb_data(c_rb_data), .rb_valid(c_rb_valid)
    );

    // Chain models: head enters mem_out[0], tail is mem_out[LEN-1]
    always @(posedge prog_clk) begin
        if (a_pre_en)        a_chain <= a_pre_val;
        else if (a_shift_en) a_chain <= {a_chain[63:0], a_head};
        if (b_pre_en)        b_chain <= b_pre_val;
        else if (b_shift_en) b_chain <= {b_chain[14:0], b_head};
        if (c_pre_en)        c_chain <= c_pre_val;
        else if (c_shift_en) c_chain <= c_head;
    end
    assign a_tail = a_chain[64];
    assign b_tail = b_chain[15];
    assign c_tail = c_chain;

    int         n_shift [3] = '{0, 0, 0};
    int         n_done  [3] = '{0, 0, 0};
    int         n_rb    [3] = '{0, 0, 0};
    logic [7:0] rb_log  [3][64];

    always @(posedge prog_clk) begin
        if (a_shift_en) n_shift[0]++;
        if (b_shift_en) n_shift[1]++;
        if (c_shift_en) n_shift[2]++;
        if (a_done) n_done[0]++;
        if (b_done) n_done[1]++;
        if (c_done) n_done[2]++;
        if (a_rb_valid) begin rb_log[0][n_rb[0] % 64] = a_rb_data; n_rb[0]++; end
        if (b_rb_valid) begin rb_log[1][n_rb[1] % 64] = b_rb_data; n_rb[1]++; end
        if (c_rb_valid) begin rb_log[2][n_rb[2] % 64] = c_rb_data; n_rb[2]++; end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int d);
        return (d == 0) ? a_in_ready : (d == 1) ? b_in_ready : c_in_ready;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? a_done : (d == 1) ? b_done : c_done;
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? a_busy : (d == 1) ? b_busy : c_busy;
    endfunction

    task automatic pulse_start(input int d);
        if (d == 0) a_start = 1'b1; else if (d == 1) b_start = 1'b1; else c_start = 1'b1;
        @(negedge prog_clk);
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    endtask

    task automatic send(input int d, input logic [7:0] w);
        int t = 0;
        if (d == 0) begin a_in_data = w; a_in_valid = 1'b1; end
        else if (d == 1) begin b_in_data = w; b_in_valid = 1'b1; end
        else begin c_in_data = w; c_in_valid = 1'b1; end
        while (!rdy_of(d) && t < 100) begin @(negedge prog_clk); t++; end
        check("in_ready_wait", 128'(t < 100), 128'(1));
        @(negedge prog_clk);
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (!done_of(d) && t < 200) begin @(negedge prog_clk); t++; end
        check("done_wait", 128'(t < 200), 128'(1));
        check("busy_in_done", 128'(busy_of(d)), 128'(0));
        @(negedge prog_clk);
        check("done_one_cycle", 128'(done_of(d)), 128'(0));
    endtask

    function automatic logic [7:0] wpat(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {n, ~n};
    endfunction

    function automatic logic [64:0] wpat_chain();
        logic [64:0] e = '0;
        for (int i = 0; i < 8; i++) e = (e << 8) | 65'(wpat(i));
        e = (e << 1) | 65'(wpat(8) >> 7);
        return e;
    endfunction

    task automatic load_wpat();
        pulse_start(0);
        for (int i = 0; i < 9; i++) send(0, wpat(i));
        wait_done(0);
    endtask

    int s0, d0, r0, t0;
    logic [64:0] snap;

    initial begin
        pReset = 1'b1;
        a_start = 0; b_start = 0; c_start = 0;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_in_data = 0; b_in_data = 0; c_in_data = 0;
        a_pre_en = 0; b_pre_en = 0; c_pre_en = 0;
        a_pre_val = '0; b_pre_val = '0; c_pre_val = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("rst_busy", 128'(a_busy), 0);
        check("rst_done", 128'(a_done), 0);
        check("rst_in_ready", 128'(a_in_ready), 0);
        check("rst_head", 128'(a_head), 0);
        check("rst_shift_en", 128'(a_shift_en), 0);
        check("rst_rb_valid", 128'(a_rb_valid), 0);
        check("rst_rb_data", 128'(a_rb_data), 0);
        pReset = 1'b0;

        // Test 1: single one ends at mem_out[0]
        a_pre_val = '1; a_pre_en = 1'b1; @(negedge prog_clk); a_pre_en = 1'b0;
        s0 = n_shift[0]; d0 = n_done[0]; r0 = n_rb[0];
        pulse_start(0);
        for (int i = 0; i < 8; i++) send(0, 8'h00);
        send(0, 8'h80);
        wait_done(0);
        repeat (2) @(negedge prog_clk);
        check("t1_shifts", 128'(n_shift[0] - s0), 128'(65));
        check("t1_done_cnt", 128'(n_done[0] - d0), 128'(1));
        check("t1_chain", 128'(a_chain), 128'({64'h0, 1'b1}));
        check("t1_rb_cnt", 128'(n_rb[0] - r0), 128'(9));
        for (int i = 0; i < 8; i++) check("t1_rb_word", 128'(rb_log[0][(r0 + i) % 64]), 128'(8'hFF));
        check("t1_rb_last", 128'(rb_log[0][(r0 + 8) % 64]), 128'(8'h80));

        // Test 2: 0xA5 words with a stall before word 3
        a_pre_val = '1; a_pre_en = 1'b1; @(negedge prog_clk); a_pre_en = 1'b0;
        s0 = n_shift[0]; r0 = n_rb[0];
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, 8'hA5);
        t0 = 0;
        while (!a_in_ready && t0 < 50) begin @(negedge prog_clk); t0++; end
        check("t2_ready_wait", 128'(t0 < 50), 128'(1));
        check("t2_head_last", 128'(a_head), 128'(1));
        snap = a_chain; t0 = n_shift[0];
        repeat (5) begin
            @(negedge prog_clk);
            check("t2_stall_shift_en", 128'(a_shift_en), 0);
        end
        check("t2_stall_shifts", 128'(n_shift[0] - t0), 0);
        check("t2_stall_chain", 128'(a_chain), 128'(snap));
        for (int i = 3; i < 9; i++) send(0, 8'hA5);
        wait_done(0);
        repeat (2) @(negedge prog_clk);
        check("t2_shifts", 128'(n_shift[0] - s0), 128'(65));
        check("t2_chain", 128'(a_chain), 128'({{8{8'hA5}}, 1'b1}));
        check("t2_rb_first", 128'(rb_log[0][r0 % 64]), 128'(8'hFF));

        // Test 3: start re-asserted mid-load is ignored
        s0 = n_shift[0]; d0 = n_done[0];
        pulse_start(0);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) pulse_start(0);
            send(0, wpat(i));
        end
        wait_done(0);
        repeat (3) @(negedge prog_clk);
        check("t3_shifts", 128'(n_shift[0] - s0), 128'(65));
        check("t3_done_cnt", 128'(n_done[0] - d0), 128'(1));
        check("t3_chain", 128'(a_chain), 128'(wpat_chain()));
        check("t3_idle_busy", 128'(a_busy), 0);

        // Test 4: reset after 20 shifted bits, then a clean reload
        a_pre_val = '0; a_pre_en = 1'b1; @(negedge prog_clk); a_pre_en = 1'b0;
        s0 = n_shift[0]; d0 = n_done[0]; r0 = n_rb[0];
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, 8'hFF);
        t0 = 0;
        while ((n_shift[0] - s0) < 20 && t0 < 50) begin @(negedge prog_clk); t0++; end
        check("t4_shift_wait", 128'(t0 < 50), 128'(1));
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0;
        check("t4_busy", 128'(a_busy), 0);
        check("t4_in_ready", 128'(a_in_ready), 0);
        check("t4_shift_en", 128'(a_shift_en), 0);
        check("t4_rb_valid", 128'(a_rb_valid), 0);
        check("t4_done", 128'(a_done), 0);
        t0 = n_shift[0];
        repeat (5) @(negedge prog_clk);
        check("t4_no_shift", 128'(n_shift[0] - t0), 0);
        check("t4_no_rb", 128'(n_rb[0] - r0), 128'(2));
        check("t4_no_done", 128'(n_done[0] - d0), 0);
        s0 = n_shift[0];
        load_wpat();
        repeat (2) @(negedge prog_clk);
        check("t4_reload_shifts", 128'(n_shift[0] - s0), 128'(65));
        check("t4_reload_chain", 128'(a_chain), 128'(wpat_chain()));

        // Test 5: 16-bit chain
        b_pre_val = 16'h1234; b_pre_en = 1'b1; @(negedge prog_clk); b_pre_en = 1'b0;
        s0 = n_shift[1]; r0 = n_rb[1];
        pulse_start(1);
        send(1, 8'h3C);
        send(1, 8'hC3);
        wait_done(1);
        repeat (2) @(negedge prog_clk);
        check("t5_shifts", 128'(n_shift[1] - s0), 128'(16));
        check("t5_rb_cnt", 128'(n_rb[1] - r0), 128'(2));
        check("t5_rb0", 128'(rb_log[1][r0 % 64]), 128'(8'h12));
        check("t5_rb1", 128'(rb_log[1][(r0 + 1) % 64]), 128'(8'h34));
        check("t5_chain", 128'(b_chain), 128'(16'h3CC3));

        // Test 6: 1-bit chain, two loads
        c_pre_val = 1'b0; c_pre_en = 1'b1; @(negedge prog_clk); c_pre_en = 1'b0;
        s0 = n_shift[2]; r0 = n_rb[2];
        pulse_start(2);
        send(2, 8'hFF);
        wait_done(2);
        repeat (2) @(negedge prog_clk);
        check("t6_shifts", 128'(n_shift[2] - s0), 128'(1));
        check("t6_chain_a", 128'(c_chain), 128'(1));
        check("t6_rb_a", 128'(rb_log[2][r0 % 64]), 128'(8'h00));
        pulse_start(2);
        send(2, 8'h7F);
        wait_done(2);
        repeat (2) @(negedge prog_clk);
        check("t6_chain_b", 128'(c_chain), 128'(0));
        check("t6_rb_b", 128'(rb_log[2][(r0 + 1) % 64]), 128'(8'h80));
        check("t6_shifts_total", 128'(n_shift[2] - s0), 128'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
